// File: rtl/ahb_fabric_slv_arb.sv
// ---------------------------------------------------------------------------
// ahb_fabric_slv_arb
//
// Per-slave-port arbiter for the AHB fabric (one instance per slave port).
// Picks which master drives the slave address phase using round-robin
// arbitration, and tracks the data-phase owner so the fabric can steer the
// hwdata/hrdata/hresp muxes. The current owner keeps the port while it holds
// HMASTLOCK. With BURST_LOCK=1 it also keeps the port for the whole of a
// fixed-length or INCR burst.
//
// Ports
//   hclk           fabric clock; all state changes on the rising edge
//   hreset         synchronous, active-high reset
//   mst_hsel       per-master decode: master m addresses this slave
//   mst_htrans     per-master HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
//   mst_hburst     per-master HBURST
//   mst_hmastlock  per-master HMASTLOCK
//   slv_hready     slave HREADY; a transfer boundary when 1
//   slv_hresp      slave HRESP; 1 = ERROR
//   addr_gnt       one-hot address-phase owner; 0 = no owner (registered)
//   addr_idx       index of addr_gnt; 0 when there is no owner (registered)
//   data_valid     a transfer is in its data phase (registered)
//   data_idx       data-phase owner index for the data muxes (registered)
// ---------------------------------------------------------------------------
module ahb_fabric_slv_arb #(
    parameter int MST        = 4,
    parameter bit BURST_LOCK = 1'b0,
    localparam int IW        = (MST > 1) ? $clog2(MST) : 1
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic [MST-1:0]       mst_hsel,
    input  logic [MST-1:0][1:0]  mst_htrans,
    input  logic [MST-1:0][2:0]  mst_hburst,
    input  logic [MST-1:0]       mst_hmastlock,
    input  logic                 slv_hready,
    input  logic                 slv_hresp,
    output logic [MST-1:0]       addr_gnt,
    output logic [IW-1:0]        addr_idx,
    output logic                 data_valid,
    output logic [IW-1:0]        data_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,    // no owner
        ST_OWN,     // owner present, re-arbitrated at every hready edge
        ST_HOLD     // owner kept (lock or burst in progress)
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;
    localparam logic [2:0] HBURST_INCR   = 3'd1;

    // Remaining SEQ beats after the NONSEQ of a fixed-length burst.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        logic [3:0] beats;
        case (hburst)
            3'd2, 3'd3: beats = 4'd3;    // WRAP4 / INCR4
            3'd4, 3'd5: beats = 4'd7;    // WRAP8 / INCR8
            3'd6, 3'd7: beats = 4'd15;   // WRAP16 / INCR16
            default:    beats = 4'd0;    // SINGLE / INCR
        endcase
        return beats;
    endfunction

    state_e          state_q, state_d;
    logic [MST-1:0]  gnt_q,   gnt_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [IW-1:0]   rr_q,    rr_d;
    logic [3:0]      beat_q,  beat_d;
    logic            incr_q,  incr_d;
    logic            dv_q,    dv_d;
    logic [IW-1:0]   didx_q,  didx_d;

    logic [MST-1:0]  req;
    logic            owned;
    logic            accept;
    logic [1:0]      o_trans;
    logic [2:0]      o_burst;
    logic            o_lock;
    logic            hold_cond;
    logic            win_found;
    logic [IW-1:0]   win_idx;

    // A master requests when it addresses this slave with NONSEQ or SEQ.
    always_comb begin
        for (int m = 0; m < MST; m++) begin
            req[m] = mst_hsel[m] & mst_htrans[m][1];
        end
    end

    // Signals presented by the current address-phase owner.
    always_comb begin
        owned   = (state_q != ST_IDLE);
        o_trans = mst_htrans[idx_q];
        o_burst = mst_hburst[idx_q];
        o_lock  = mst_hmastlock[idx_q];
        accept  = slv_hready & owned & req[idx_q];
    end

    // Round-robin search starting just after the last winner. The last
    // candidate examined is rr_q itself, so the previous winner only keeps
    // the port when nobody else is asking.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= MST; k++) begin
            if (!win_found && req[(int'(rr_q) + k) % MST]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(rr_q) + k) % MST);
            end
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        rr_d      = rr_q;
        beat_d    = beat_q;
        incr_d    = incr_q;
        dv_d      = dv_q;
        didx_d    = didx_q;
        hold_cond = 1'b0;

        if (slv_hready) begin
            // The accepted address moves into its data phase.
            dv_d = accept;
            if (accept) begin
                didx_d = idx_q;
            end

            if (BURST_LOCK) begin
                if (accept && o_trans == HTRANS_NONSEQ) begin
                    beat_d = burst_beats(o_burst);
                    incr_d = (o_burst == HBURST_INCR);
                end else begin
                    if (accept && o_trans == HTRANS_SEQ && beat_q != 4'd0) begin
                        beat_d = beat_q - 4'd1;
                    end
                    // An undefined-length burst ends when the owner stops
                    // presenting SEQ/BUSY.
                    if (o_trans == HTRANS_IDLE || o_trans == HTRANS_NONSEQ) begin
                        incr_d = 1'b0;
                    end
                end
            end

            hold_cond = owned && (o_lock || (beat_d != 4'd0) || incr_d);

            if ((accept || state_q == ST_HOLD) && hold_cond) begin
                state_d = ST_HOLD;
            end else begin
                // Ownership may move; burst tracking belongs to the old owner.
                beat_d = 4'd0;
                incr_d = 1'b0;
                if (win_found) begin
                    state_d = ST_OWN;
                    gnt_d   = MST'(1) << win_idx;
                    idx_d   = win_idx;
                    if (!owned || win_idx != idx_q) begin
                        rr_d = win_idx;
                    end
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                end
            end
        end else if (slv_hresp) begin
            // First cycle of an ERROR response: the burst is abandoned, so
            // only a lock can keep the owner at the next hready edge.
            beat_d = 4'd0;
            incr_d = 1'b0;
        end
    end

    always_ff @(posedge hclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (hreset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            rr_q    <= IW'(MST - 1);   // master 0 wins the first arbitration
            beat_q  <= 4'd0;
            incr_q  <= 1'b0;
            dv_q    <= 1'b0;
            didx_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            incr_q  <= incr_d;
            dv_q    <= dv_d;
            didx_q  <= didx_d;
        end
    end

    assign addr_gnt   = gnt_q;
    assign addr_idx   = idx_q;
    assign data_valid = dv_q;
    assign data_idx   = didx_q;

endmodule

// File: tb/tb_ahb_fabric_slv_arb.sv
// ---------------------------------------------------------------------------
// tb_ahb_fabric_slv_arb
//
// Drives two arbiters from the same master/slave signals: u_dut0 with
// BURST_LOCK=0 and u_dut1 with BURST_LOCK=1. Each directed step pushes the
// hand-derived expected outputs onto a scoreboard queue, clocks one edge, then
// pops the entry and compares it with the registered outputs 1 time unit
// after the edge.
// ---------------------------------------------------------------------------
module tb_ahb_fabric_slv_arb;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] NS   = 2'd2;
    localparam logic [1:0] SEQ  = 2'd3;

    logic            hclk;
    logic            hreset;
    logic [3:0]      hsel;
    logic [3:0][1:0] htrans;
    logic [3:0][2:0] hburst;
    logic [3:0]      hlock;
    logic            hready;
    logic            hresp;

    logic [3:0]      gnt0, gnt1;
    logic [1:0]      idx0, idx1;
    logic            dv0,  dv1;
    logic [1:0]      didx0, didx1;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string      tag;
        logic [1:0] mask;     // bit0: check u_dut0, bit1: check u_dut1
        logic [3:0] g0;
        logic       v0;
        logic [1:0] d0;
        logic [3:0] g1;
        logic       v1;
        logic [1:0] d1;
    } exp_t;

    exp_t sb_q[$];

    // Expected results for m1's INCR4 (with BUSY) against a steady m3 request.
    localparam logic [1:0] T2_TR [8] = '{NS, NS, BUSY, SEQ, BUSY, SEQ, SEQ, IDLE};
    localparam logic [3:0] T2_G1 [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                         4'b0010, 4'b0010, 4'b1000, 4'b1000};
    localparam logic       T2_V1 [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [1:0] T2_D1 [8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3};
    localparam logic [3:0] T2_G0 [8] = '{4'b0010, 4'b1000, 4'b1000, 4'b0010,
                                         4'b1000, 4'b0010, 4'b1000, 4'b1000};
    localparam logic       T2_V0 [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [1:0] T2_D0 [8] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd3};

    ahb_fabric_slv_arb #(.MST(4), .BURST_LOCK(1'b0)) u_dut0 (
        .hclk          (hclk),
        .hreset        (hreset),
        .mst_hsel      (hsel),
        .mst_htrans    (htrans),
        .mst_hburst    (hburst),
        .mst_hmastlock (hlock),
        .slv_hready    (hready),
        .slv_hresp     (hresp),
        .addr_gnt      (gnt0),
        .addr_idx      (idx0),
        .data_valid    (dv0),
        .data_idx      (didx0)
    );

    ahb_fabric_slv_arb #(.MST(4), .BURST_LOCK(1'b1)) u_dut1 (
        .hclk          (hclk),
        .hreset        (hreset),
        .mst_hsel      (hsel),
        .mst_htrans    (htrans),
        .mst_hburst    (hburst),
        .mst_hmastlock (hlock),
        .slv_hready    (hready),
        .slv_hresp     (hresp),
        .addr_gnt      (gnt1),
        .addr_idx      (idx1),
        .data_valid    (dv1),
        .data_idx      (didx1)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected $finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] onehot_idx(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic compare_front();
        exp_t e;
        e = sb_q.pop_front();
        if (e.mask[0]) begin
            check({e.tag, " bl0.addr_gnt"},   32'(gnt0),  32'(e.g0));
            check({e.tag, " bl0.addr_idx"},   32'(idx0),  32'(onehot_idx(e.g0)));
            check({e.tag, " bl0.data_valid"}, 32'(dv0),   32'(e.v0));
            check({e.tag, " bl0.data_idx"},   32'(didx0), 32'(e.d0));
        end
        if (e.mask[1]) begin
            check({e.tag, " bl1.addr_gnt"},   32'(gnt1),  32'(e.g1));
            check({e.tag, " bl1.addr_idx"},   32'(idx1),  32'(onehot_idx(e.g1)));
            check({e.tag, " bl1.data_valid"}, 32'(dv1),   32'(e.v1));
            check({e.tag, " bl1.data_idx"},   32'(didx1), 32'(e.d1));
        end
    endtask

    // One edge with separate expectations for the two arbiters.
    task automatic step2(input string tag,
                         input logic [3:0] g1, input logic v1, input logic [1:0] d1,
                         input logic [3:0] g0, input logic v0, input logic [1:0] d0);
        exp_t e;
        e.tag = tag; e.mask = 2'b11;
        e.g0 = g0; e.v0 = v0; e.d0 = d0;
        e.g1 = g1; e.v1 = v1; e.d1 = d1;
        sb_q.push_back(e);
        @(posedge hclk);
        #1;
        compare_front();
    endtask

    // One edge with a shared expectation, checked on the arbiters in mask.
    task automatic step(input string tag, input logic [1:0] mask,
                        input logic [3:0] g, input logic v, input logic [1:0] d);
        exp_t e;
        e.tag = tag; e.mask = mask;
        e.g0 = g; e.v0 = v; e.d0 = d;
        e.g1 = g; e.v1 = v; e.d1 = d;
        sb_q.push_back(e);
        @(posedge hclk);
        #1;
        compare_front();
    endtask

    task automatic drive(input int m, input logic sel, input logic [1:0] tr,
                         input logic [2:0] bu, input logic lk);
        hsel[m]   = sel;
        htrans[m] = tr;
        hburst[m] = bu;
        hlock[m]  = lk;
    endtask

    task automatic clear_inputs();
        hsel   = '0;
        htrans = '0;
        hburst = '0;
        hlock  = '0;
        hready = 1'b1;
        hresp  = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        hreset = 1'b1;
        step(tag, 2'b11, 4'b0000, 1'b0, 2'd0);
        hreset = 1'b0;
    endtask

    initial begin
        do_reset("reset");

        // Round-robin between m0 and m2; master 0 wins first out of reset.
        drive(0, 1'b1, NS, 3'd0, 1'b0);
        drive(2, 1'b1, NS, 3'd0, 1'b0);
        step("rr_first",   2'b11, 4'b0001, 1'b0, 2'd0);
        step("rr_rotate",  2'b11, 4'b0100, 1'b1, 2'd0);
        step("rr_back",    2'b11, 4'b0001, 1'b1, 2'd2);
        drive(0, 1'b0, IDLE, 3'd0, 1'b0);
        drive(2, 1'b0, IDLE, 3'd0, 1'b0);
        step("rr_idle",    2'b11, 4'b0000, 1'b0, 2'd2);

        // m1 INCR4 with two BUSY beats; m3 requests throughout.
        do_reset("reset_t2");
        for (int s = 0; s < 8; s++) begin
            drive(1, 1'b1, T2_TR[s], 3'd3, 1'b0);
            drive(3, 1'b1, NS, 3'd0, 1'b0);
            step2($sformatf("incr4_e%0d", s + 1),
                  T2_G1[s], T2_V1[s], T2_D1[s], T2_G0[s], T2_V0[s], T2_D0[s]);
        end

        // m2 keeps the port for three locked transfers while everyone requests.
        do_reset("reset_lock");
        for (int m = 0; m < 4; m++) drive(m, 1'b1, NS, 3'd0, (m == 2));
        step("lock_e1", 2'b11, 4'b0001, 1'b0, 2'd0);
        step("lock_e2", 2'b11, 4'b0010, 1'b1, 2'd0);
        step("lock_e3", 2'b11, 4'b0100, 1'b1, 2'd1);
        step("lock_e4", 2'b11, 4'b0100, 1'b1, 2'd2);
        step("lock_e5", 2'b11, 4'b0100, 1'b1, 2'd2);
        step("lock_e6", 2'b11, 4'b0100, 1'b1, 2'd2);
        drive(2, 1'b1, IDLE, 3'd0, 1'b0);
        step("lock_release", 2'b11, 4'b1000, 1'b0, 2'd2);
        step("lock_resume",  2'b11, 4'b0001, 1'b1, 2'd3);

        // ERROR on beat 2 of m0's INCR8 releases the burst hold.
        do_reset("reset_err");
        drive(0, 1'b1, NS, 3'd5, 1'b0);
        drive(1, 1'b1, NS, 3'd0, 1'b0);
        step("err_grant", 2'b10, 4'b0001, 1'b0, 2'd0);
        step("err_beat1", 2'b10, 4'b0001, 1'b1, 2'd0);
        drive(0, 1'b1, SEQ, 3'd5, 1'b0);
        step("err_beat2", 2'b10, 4'b0001, 1'b1, 2'd0);
        hready = 1'b0;
        hresp  = 1'b1;
        step("err_cycle1", 2'b10, 4'b0001, 1'b1, 2'd0);
        hready = 1'b1;
        drive(0, 1'b1, IDLE, 3'd5, 1'b0);
        step("err_rearb", 2'b10, 4'b0010, 1'b0, 2'd0);
        hresp = 1'b0;
        step("err_next",  2'b10, 4'b0010, 1'b1, 2'd1);

        // Five wait states mid-data-phase freeze everything, then reset mid-burst.
        do_reset("reset_frz");
        drive(2, 1'b1, NS, 3'd3, 1'b0);
        drive(3, 1'b1, NS, 3'd0, 1'b0);
        step2("frz_grant", 4'b0100, 1'b0, 2'd0, 4'b0100, 1'b0, 2'd0);
        step2("frz_beat1", 4'b0100, 1'b1, 2'd2, 4'b1000, 1'b1, 2'd2);
        drive(2, 1'b1, SEQ, 3'd3, 1'b0);
        hready = 1'b0;
        for (int w = 0; w < 5; w++) begin
            step2($sformatf("frz_wait%0d", w + 1),
                  4'b0100, 1'b1, 2'd2, 4'b1000, 1'b1, 2'd2);
        end
        hready = 1'b1;
        step2("frz_resume", 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 2'd3);
        hreset = 1'b1;
        step("frz_reset", 2'b11, 4'b0000, 1'b0, 2'd0);
        hreset = 1'b0;
        drive(2, 1'b1, IDLE, 3'd3, 1'b0);
        step("frz_restart", 2'b11, 4'b1000, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
